qq_cmd_issuer: RTL and testbench
================================

QQ_CMD_ISSUER -- requirements
Module: qq_cmd_issuer

Interface
REQ-001 SHALL have parameter W, default 8: key/value width in bits.
REQ-002 SHALL have parameter DEPTH, default 4: command FIFO entries, power of two, minimum 2.
REQ-003 SHALL have parameter WDOG, default 255: maximum cycles to wait for queue completion.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port cmd_valid, input, 1 bit: upstream command present.
REQ-008 SHALL have port cmd_ready, output, 1 bit: command FIFO can accept.
REQ-009 SHALL have port cmd_op, input, 2 bits: 00 enq, 01 deq, 10 repl, 11 illegal.
REQ-010 SHALL have port cmd_key, input, W bits: key (priority) for enq/repl.
REQ-011 SHALL have port cmd_val, input, W bits: payload for enq/repl.
REQ-012 SHALL have ports enq, deq, repl, output, 1 bit each: single-cycle operation pulses to qq_top.
REQ-013 SHALL have ports lt_i and rt_i, output, W bits each: key and payload to qq_top.
REQ-014 SHALL have ports lt_o and rt_o, input, W bits each: head key and head payload from qq_top.
REQ-015 SHALL have ports full_t, empty_t and rdy_t, input, 1 bit each: queue status from qq_top.
REQ-016 SHALL have port rsp_valid, output, 1 bit: response available.
REQ-017 SHALL have port rsp_ready, input, 1 bit: downstream accepts response.
REQ-018 SHALL have ports rsp_key and rsp_val, output, W bits each: removed head (deq/repl), else 0.
REQ-019 SHALL have port rsp_err, output, 2 bits: 00 ok, 01 rejected (full/empty), 10 illegal op, 11 watchdog timeout.

Function
REQ-020 SHALL push {op, key, val} into the FIFO when cmd_valid and cmd_ready are both high at a clock edge.
REQ-021 SHALL drive cmd_ready as (count < DEPTH) from registered count; a pop in the same cycle SHALL NOT raise cmd_ready combinationally.
REQ-022 SHALL wrap FIFO read/write pointers modulo DEPTH; count SHALL be DEPTH+1 bits wide, never overflow or underflow.
REQ-023 SHALL implement FSM states IDLE, CHECK, ISSUE, WAIT, RESP.
REQ-024 IDLE -> CHECK when FIFO non-empty and rsp_valid low; CHECK SHALL pop the head entry into a command register.
REQ-025 CHECK -> RESP with rsp_err=10 if op=11; rsp_err=01 if op=enq and full_t=1; rsp_err=01 if op=deq/repl and empty_t=1; no pulse is issued in any of these cases.
REQ-026 CHECK -> ISSUE otherwise; ISSUE SHALL hold until rdy_t=1, then assert exactly one of enq/deq/repl for exactly one cycle, with lt_i/rt_i valid in that cycle.
REQ-027 For deq/repl, SHALL capture lt_o/rt_o into rsp_key/rsp_val in the ISSUE pulse cycle (pre-operation head); for enq, rsp_key/rsp_val SHALL be 0.
REQ-028 WAIT SHALL start the cycle after the pulse; completion is the first cycle with rdy_t=1 after at least one cycle of rdy_t=0 has been seen in WAIT.
REQ-029 WAIT SHALL count cycles; reaching WDOG without completion SHALL go to RESP with rsp_err=11.
REQ-030 On completion, WAIT -> RESP with rsp_err=00.
REQ-031 RESP SHALL hold rsp_valid=1 with stable rsp_* until rsp_ready=1, then return to IDLE; back-to-back minimum is 1 command per 5 cycles plus queue latency.
REQ-032 lt_i/rt_i SHALL hold the last issued values between operations; enq/deq/repl SHALL be 0 outside ISSUE pulse cycles.
REQ-033 Commands SHALL be issued strictly in FIFO order; at most one queue operation is outstanding.

Reset
REQ-034 While rst=0: FIFO empty, pointers 0, FSM IDLE, cmd_ready=1, enq=deq=repl=0, lt_i=rt_i=0, rsp_valid=0, rsp_key=rsp_val=0, rsp_err=00, watchdog=0.
REQ-035 Reset asserted mid-operation SHALL discard buffered and in-flight commands with no further pulse; deassertion SHALL be synchronised so the first active edge sees IDLE.

Verification
REQ-036 Enq keys 5,10,3,20 back-to-back against a qq_top model -> four single-cycle enq pulses in order, four rsp_err=00, FIFO stalls cmd_ready=0 when 4 are buffered.
REQ-037 After REQ-036, deq x4 -> rsp_key sequence 3,5,10,20; a fifth deq -> rsp_err=01 with no deq pulse.
REQ-038 Queue full (8 entries), enq key 27 -> rsp_err=01, no enq pulse; repl key 9 -> rsp_key equals old minimum, rsp_err=00.
REQ-039 cmd_op=11 -> rsp_err=10, no pulse; hold rsp_ready=0 for 10 cycles -> rsp_* stable, no further issue.
REQ-040 Model keeps rdy_t=1 forever after the pulse -> rsp_err=11 exactly WDOG cycles after WAIT entry.
REQ-041 Assert rst during WAIT with 3 commands buffered -> all outputs at reset values, no pulses after release until a new cmd is pushed.

Source files
------------

// File: rtl/qq_cmd_issuer.sv
// Command issuer for a priority queue (qq_top): buffers commands in a small FIFO,
// screens them against queue status, issues one operation at a time and reports a response.
module qq_cmd_issuer #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int WDOG  = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [W-1:0] cmd_key,
  input  logic [W-1:0] cmd_val,
  output logic         enq,
  output logic         deq,
  output logic         repl,
  output logic [W-1:0] lt_i,
  output logic [W-1:0] rt_i,
  input  logic [W-1:0] lt_o,
  input  logic [W-1:0] rt_o,
  input  logic         full_t,
  input  logic         empty_t,
  input  logic         rdy_t,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_key,
  output logic [W-1:0] rsp_val,
  output logic [1:0]   rsp_err
);
  localparam int AW  = $clog2(DEPTH);
  localparam int WDW = $clog2(WDOG + 1);
  localparam logic [DEPTH:0] DEPTH_C = (DEPTH + 1)'(DEPTH);
  localparam logic [WDW-1:0] WD_LAST = WDW'(WDOG - 1);

  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic [2*W+1:0]   mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [DEPTH:0]   cnt_q;
  logic [1:0]       op_q, op_d;
  logic [W-1:0]     lt_q, lt_d, rt_q, rt_d;
  logic [W-1:0]     rkey_q, rkey_d, rval_q, rval_d;
  logic [1:0]       err_q, err_d;
  logic [WDW-1:0]   wd_q, wd_d;
  logic             seen_q, seen_d;
  logic             push, pop;
  logic [1:0]       h_op;
  logic [W-1:0]     h_key, h_val;

  assign cmd_ready = (cnt_q < DEPTH_C);
  assign push      = cmd_valid & cmd_ready;
  assign pop       = (state_q == CHECK);
  assign {h_op, h_key, h_val} = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {cmd_op, cmd_key, cmd_val};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      lt_q    <= '0;
      rt_q    <= '0;
      rkey_q  <= '0;
      rval_q  <= '0;
      err_q   <= '0;
      wd_q    <= '0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      lt_q    <= lt_d;
      rt_q    <= rt_d;
      rkey_q  <= rkey_d;
      rval_q  <= rval_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
      seen_q  <= seen_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    lt_d    = lt_q;
    rt_d    = rt_q;
    rkey_d  = rkey_q;
    rval_d  = rval_q;
    err_d   = err_q;
    wd_d    = wd_q;
    seen_d  = seen_q;
    enq     = 1'b0;
    deq     = 1'b0;
    repl    = 1'b0;
    case (state_q)
      IDLE: if (cnt_q != '0) state_d = CHECK;
      CHECK: begin
        op_d   = h_op;
        rkey_d = '0;
        rval_d = '0;
        if (h_op == 2'b11) begin
          err_d   = 2'b10;
          state_d = RESP;
        end else if ((h_op == 2'b00 && full_t) || (h_op != 2'b00 && empty_t)) begin
          err_d   = 2'b01;
          state_d = RESP;
        end else begin
          // Operands are loaded now so they are already stable in the pulse cycle.
          err_d   = 2'b00;
          lt_d    = h_key;
          rt_d    = h_val;
          state_d = ISSUE;
        end
      end
      ISSUE: if (rdy_t) begin
        enq  = (op_q == 2'b00);
        deq  = (op_q == 2'b01);
        repl = (op_q == 2'b10);
        if (op_q != 2'b00) begin
          rkey_d = lt_o;
          rval_d = rt_o;
        end
        wd_d    = '0;
        seen_d  = 1'b0;
        state_d = WAIT;
      end
      WAIT: begin
        // Completion needs a busy (rdy_t low) phase first; rdy_t still high from the pulse doesn't count.
        if (seen_q && rdy_t) begin
          err_d   = 2'b00;
          state_d = RESP;
        end else if (wd_q == WD_LAST) begin
          err_d   = 2'b11;
          state_d = RESP;
        end else begin
          wd_d = wd_q + 1'b1;
          if (!rdy_t) seen_d = 1'b1;
        end
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign lt_i      = lt_q;
  assign rt_i      = rt_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_key   = rkey_q;
  assign rsp_val   = rval_q;
  assign rsp_err   = err_q;
endmodule

// File: tb/tb_qq_cmd_issuer.sv
// Scoreboard bench for qq_cmd_issuer: a priority-queue stub plays qq_top, a sorted-list
// reference predicts every response and pulse, and a negedge monitor checks them.
module tb_qq_cmd_issuer;
  localparam int W = 8, DEPTH = 4, WDOG = 40, QCAP = 8;

  logic clk = 0, rst = 0;
  logic cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [W-1:0] cmd_key, cmd_val;
  logic enq, deq, repl;
  logic [W-1:0] lt_i, rt_i;
  logic [W-1:0] lt_o = 0, rt_o = 0;
  logic full_t = 0, empty_t = 1, rdy_t = 1;
  logic rsp_valid, rsp_ready = 0;
  logic [W-1:0] rsp_key, rsp_val;
  logic [1:0] rsp_err;

  always #5 clk = ~clk;

  qq_cmd_issuer #(.W(W), .DEPTH(DEPTH), .WDOG(WDOG)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_key(cmd_key), .cmd_val(cmd_val), .enq(enq), .deq(deq), .repl(repl),
    .lt_i(lt_i), .rt_i(rt_i), .lt_o(lt_o), .rt_o(rt_o), .full_t(full_t), .empty_t(empty_t),
    .rdy_t(rdy_t), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_key(rsp_key),
    .rsp_val(rsp_val), .rsp_err(rsp_err));

  typedef struct {logic [1:0] err; logic [W-1:0] k; logic [W-1:0] v;} rsp_t;
  typedef struct {logic [1:0] op; logic [W-1:0] k; logic [W-1:0] v;} op_t;

  rsp_t exp_rsp[$];
  op_t  exp_op[$];
  logic [W-1:0] ref_k[$], ref_v[$];
  logic [W-1:0] sq_k[$], sq_v[$];
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, pulse_cnt = 0, last_pulse_cyc = 0;
  bit stuck = 0, hold = 1, prev_rv = 0, prev_pl = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic bad(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", nm);
  endtask

  // Reference: queue kept sorted by key (ties in arrival order); head is always element 0.
  task automatic ref_cmd(input logic [1:0] op, input logic [W-1:0] k, input logic [W-1:0] v);
    rsp_t r;
    op_t  o;
    int   i;
    r.err = 2'b00; r.k = '0; r.v = '0;
    if (op == 2'b11) r.err = 2'b10;
    else if (op == 2'b00 && ref_k.size() == QCAP) r.err = 2'b01;
    else if (op != 2'b00 && ref_k.size() == 0) r.err = 2'b01;
    else begin
      if (op != 2'b00) begin
        r.k = ref_k.pop_front();
        r.v = ref_v.pop_front();
      end
      if (op != 2'b01) begin
        i = 0;
        while (i < ref_k.size() && ref_k[i] <= k) i++;
        ref_k.insert(i, k);
        ref_v.insert(i, v);
      end
      if (stuck) r.err = 2'b11;
      o.op = op; o.k = k; o.v = v;
      exp_op.push_back(o);
    end
    exp_rsp.push_back(r);
  endtask

  // qq_top stub: unsorted store, head found by linear min search.
  int busy = 0, m_st;
  function automatic int min_idx();
    int m = 0;
    for (int j = 1; j < sq_k.size(); j++) if (sq_k[j] < sq_k[m]) m = j;
    return m;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      sq_k.delete(); sq_v.delete();
      busy = 0;
      rdy_t <= 1'b1; lt_o <= '0; rt_o <= '0; full_t <= 1'b0; empty_t <= 1'b1;
    end else begin
      if (enq | deq | repl) begin
        if ((deq | repl) && sq_k.size() > 0) begin
          m_st = min_idx();
          sq_k.delete(m_st); sq_v.delete(m_st);
        end
        if (enq | repl) begin
          sq_k.push_back(lt_i); sq_v.push_back(rt_i);
        end
        if (stuck) rdy_t <= 1'b1;
        else begin
          busy = $urandom_range(1, 3);
          rdy_t <= 1'b0;
        end
      end else if (busy > 0) begin
        busy--;
        rdy_t <= (busy == 0);
      end else rdy_t <= stuck ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (sq_k.size() > 0) begin
        m_st = min_idx();
        lt_o <= sq_k[m_st]; rt_o <= sq_v[m_st];
      end else begin
        lt_o <= '0; rt_o <= '0;
      end
      full_t  <= (sq_k.size() == QCAP);
      empty_t <= (sq_k.size() == 0);
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    rsp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  int   mon_np, mon_op;
  op_t  mon_eo;
  rsp_t mon_er;
  always @(negedge clk) begin
    if (!rst) begin
      prev_rv = 0; prev_pl = 0;
    end else begin
      mon_np = int'(enq) + int'(deq) + int'(repl);
      if (mon_np > 1) bad("pulse_onehot");
      if (mon_np != 0) begin
        if (prev_pl) bad("pulse_width");
        pulse_cnt++;
        last_pulse_cyc = cyc;
        if (exp_op.size() == 0) bad("unexpected_pulse");
        else begin
          mon_eo = exp_op.pop_front();
          mon_op = deq ? 1 : (repl ? 2 : 0);
          chk("pulse_op", mon_op, mon_eo.op);
          if (mon_eo.op != 2'b01) begin
            chk("pulse_lt_i", lt_i, mon_eo.k);
            chk("pulse_rt_i", rt_i, mon_eo.v);
          end
        end
      end
      if (rsp_valid && !prev_rv && stuck) chk("wdog_latency", cyc - last_pulse_cyc, WDOG + 1);
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp.size() == 0) bad("unexpected_rsp");
        else begin
          mon_er = exp_rsp.pop_front();
          chk("rsp_err", rsp_err, mon_er.err);
          chk("rsp_key", rsp_key, mon_er.k);
          chk("rsp_val", rsp_val, mon_er.v);
        end
      end
      prev_rv = rsp_valid;
      prev_pl = (mon_np != 0);
    end
  end

  task automatic push(input logic [1:0] op, input logic [W-1:0] k, input logic [W-1:0] v);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_op = op; cmd_key = k; cmd_val = v;
    while (!cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) bad("cmd_ready_timeout");
    else ref_cmd(op, k, v);
    @(posedge clk);
    #1 cmd_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_rsp.size() != 0 || exp_op.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) bad("drain_timeout");
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_pulses"}, {enq, deq, repl}, 0);
    chk({tag, "_lt_i"}, lt_i, 0);
    chk({tag, "_rt_i"}, rt_i, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_key"}, rsp_key, 0);
    chk({tag, "_rsp_val"}, rsp_val, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int pc, n, r;
    logic [1:0] op;
    cmd_valid = 0; cmd_op = 0; cmd_key = 0; cmd_val = 0;
    repeat (3) @(negedge clk);
    reset_vals("reset");
    rst = 1;
    @(negedge clk);

    // illegal op with the response held off for 10 cycles
    push(2'b11, 8'hAA, 8'h55);
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) bad("rsp_valid_timeout");
    pc = pulse_cnt;
    repeat (10) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_err", rsp_err, 2);
      chk("hold_key", rsp_key, 0);
      chk("hold_val", rsp_val, 0);
      chk("hold_nopulse", pulse_cnt, pc);
    end
    push(2'b00, 8'd5, 8'h50);
    push(2'b00, 8'd10, 8'h51);
    push(2'b00, 8'd3, 8'h52);
    push(2'b00, 8'd20, 8'h53);
    @(negedge clk);
    chk("stall_cmd_ready", cmd_ready, 0);
    hold = 0;
    drain();

    // deq x4 yields 3,5,10,20; the fifth is rejected without a pulse
    repeat (5) push(2'b01, 8'd0, 8'd0);
    drain();

    // fill to 8, enq while full is rejected, repl returns the old minimum
    for (int i = 0; i < QCAP; i++) push(2'b00, 8'($urandom_range(30, 250)), 8'($urandom));
    push(2'b00, 8'd27, 8'h77);
    push(2'b10, 8'd9, 8'h99);
    drain();

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      op = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      push(op, 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    drain();

    // watchdog: the stub never drops rdy_t after the pulse
    stuck = 1;
    push((ref_k.size() > 0) ? 2'b01 : 2'b00, 8'd44, 8'd45);
    drain();
    stuck = 0;
    repeat (3) @(negedge clk);

    // reset while one command waits and three are buffered
    stuck = 1;
    pc = pulse_cnt;
    push((ref_k.size() > 0) ? 2'b01 : 2'b00, 8'd60, 8'd61);
    repeat (3) push(2'b11, 8'd1, 8'd1);
    n = 0;
    while (pulse_cnt == pc && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) bad("wait_pulse_timeout");
    repeat (3) @(negedge clk);
    rst = 0;
    exp_rsp.delete(); exp_op.delete(); ref_k.delete(); ref_v.delete();
    stuck = 0;
    @(negedge clk);
    reset_vals("midop_reset");
    repeat (2) @(negedge clk);
    rst = 1;
    pc = pulse_cnt;
    repeat (20) @(negedge clk);
    chk("post_reset_nopulse", pulse_cnt, pc);
    chk("post_reset_rsp_valid", rsp_valid, 0);
    chk("post_reset_cmd_ready", cmd_ready, 1);
    push(2'b00, 8'd1, 8'd2);
    drain();
    chk("post_reset_one_pulse", pulse_cnt, pc + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
